// File: rtl/aes_block_packer.sv
// Packs a plaintext byte stream into 128-bit AES blocks and hands each one to aes_uart.
// A message end is padded with PKCS#7 (or zero-filled); a full final block is followed by an all-0x10 block.
module aes_block_packer #(
    parameter logic PAD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [127:0] blk_data,
    output logic         en_tx,
    input  logic         u_tx_done,
    output logic         pad_blk,
    output logic [15:0]  blk_count
);

    typedef enum logic [1:0] {FILL, PAD, SEND} state_e;

    state_e         state_q, state_d;
    logic [127:0]   data_q, data_d;
    logic [3:0]     idx_q, idx_d;
    logic           pad_q, pad_d;
    logic           xtra_q, xtra_d;
    logic [15:0]    cnt_q, cnt_d;

    logic [4:0]     pad_n;
    logic [7:0]     pad_byte;

    // In PAD, idx_q holds the number of data bytes n; n=0 yields the all-0x10 extra block.
    assign pad_n    = 5'd16 - {1'b0, idx_q};
    assign pad_byte = PAD_EN ? {3'b000, pad_n} : 8'h00;

    assign s_ready   = (state_q == FILL);
    assign en_tx     = (state_q == SEND);
    assign blk_data  = data_q;
    assign pad_blk   = pad_q;
    assign blk_count = cnt_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        pad_d   = pad_q;
        xtra_d  = xtra_q;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (s_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        if (i[3:0] == idx_q) data_d[8*(15-i) +: 8] = s_data;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = SEND;
                        if (s_last) xtra_d = PAD_EN;
                    end else if (s_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < 16; i++) begin
                    if (i[3:0] >= idx_q) data_d[8*(15-i) +: 8] = pad_byte;
                end
                pad_d   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (u_tx_done) begin
                    cnt_d   = cnt_q + 16'd1;
                    idx_d   = 4'd0;
                    pad_d   = 1'b0;
                    xtra_d  = 1'b0;
                    // The extra block is built by PAD with n=0, which also gives en_tx its low cycle.
                    state_d = xtra_q ? PAD : FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            data_q  <= '0;
            idx_q   <= '0;
            pad_q   <= 1'b0;
            xtra_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
            xtra_q  <= xtra_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 The block SHALL have parameter PAD_EN, default 1: 1 selects PKCS#7 padding on message end; 0 selects zero-fill with no extra block.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port s_data, input, 8 bits: plaintext byte from the upstream source.
REQ-005 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-006 The block SHALL have port s_last, input, 1 bit: the current byte is the final byte of a message; meaningful only when s_valid=1.
REQ-007 The block SHALL have port s_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port blk_data, output, 128 bits: assembled block, driving the aes_uart data_in.
REQ-009 The block SHALL have port en_tx, output, 1 bit: transmit request, driving the aes_uart en_tx.
REQ-010 The block SHALL have port u_tx_done, input, 1 bit: the aes_uart transmit-complete pulse.
REQ-011 The block SHALL have port pad_blk, output, 1 bit: the block currently presented contains padding.
REQ-012 The block SHALL have port blk_count, output, 16 bits: number of blocks completed.

Function
REQ-013 A byte SHALL be accepted only on a rising edge where s_valid=1 and s_ready=1; while s_ready=0 the source holds its byte, and no byte is dropped.
REQ-014 The first byte of a block SHALL be written to blk_data[127:120], the second to [119:112], and so on, with the 16th byte at [7:0].
REQ-015 The FSM SHALL have states FILL, PAD and SEND; s_ready=1 only in FILL.
REQ-016 A 4-bit byte counter idx SHALL count accepted bytes in the current block.
REQ-017 FILL: accepting the 16th byte with s_last=0 SHALL move the FSM to SEND on the next cycle, and s_ready SHALL be 0 from that cycle.
REQ-018 FILL with an accepted byte where s_last=1 and the block is partial (n = idx+1 < 16) SHALL move the FSM to PAD.
REQ-019 FILL with an accepted byte where s_last=1 and the block is full (n=16) SHALL move the FSM to SEND; if PAD_EN=1 it SHALL also set an internal flag xtra_pend.
REQ-020 PAD SHALL last exactly one cycle: bytes n..15 are filled with value 16-n if PAD_EN=1, otherwise 0x00; pad_blk is set to 1; the FSM then moves to SEND.
REQ-021 SEND: en_tx SHALL be 1 from the first SEND cycle, and blk_data SHALL remain stable for as long as en_tx=1.
REQ-022 SEND with u_tx_done=1 on an edge SHALL, on the next cycle: set en_tx=0; increment blk_count (modulo 2^16, so 0xFFFF wraps to 0x0000); clear idx and pad_blk.
REQ-023 After SEND completes with xtra_pend=0, the FSM SHALL return to FILL.
REQ-024 After SEND completes with xtra_pend=1, the block SHALL load sixteen bytes of 0x10 into blk_data, set pad_blk=1, clear xtra_pend and re-enter SEND.
REQ-025 u_tx_done SHALL be ignored in FILL and PAD.
REQ-026 u_tx_done held high for several cycles SHALL complete only one block, because the FSM leaves SEND after the first sampled cycle.
REQ-027 s_last=1 with s_valid=0 SHALL have no effect.
REQ-028 Worst-case latency from the last byte accepted to en_tx=1 SHALL be 2 cycles (through PAD); for a full block without s_last it SHALL be 1 cycle.

Reset
REQ-029 reset=0 SHALL immediately and asynchronously force: state=FILL, s_ready=1 once reset is released, en_tx=0, blk_data=0, idx=0, pad_blk=0, xtra_pend=0, blk_count=0.
REQ-030 Reset asserted mid-block or during SEND SHALL discard the partial data and the pending transmit; en_tx SHALL fall without waiting for u_tx_done.

Verification
REQ-031 Send bytes 0x00..0x0F with s_last on 0x0F -> blk_data=00010203..0E0F, en_tx=1 one cycle after acceptance, pad_blk=0; after u_tx_done, a second block of sixteen 0x10 bytes is sent with pad_blk=1, and blk_count=2.
REQ-032 Send 0xAA,0xBB,0xCC with s_last on 0xCC and PAD_EN=1 -> blk_data=AABBCC followed by thirteen 0x0D bytes, pad_blk=1, en_tx=1 two cycles after acceptance.
REQ-033 Repeat the 0xAA,0xBB,0xCC case with PAD_EN=0 -> blk_data=AABBCC followed by 0x00 bytes, no extra block, blk_count=1.
REQ-034 Hold s_valid=1 continuously with u_tx_done delayed 200 cycles -> s_ready=0 and blk_data stable throughout SEND; no byte is lost across 3 consecutive blocks.
REQ-035 Assert reset=0 after 7 bytes, then stream 16 new bytes -> blk_data contains only the new bytes, and blk_count=1 after done.
REQ-036 Preload blk_count=0xFFFF by running 65535 blocks (or force in simulation), then complete one more block -> blk_count=0x0000.
